// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed byte image into instruction memory and holds the core until done.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_BYTES = 1241,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_error_o
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_TAIL  = S_CSUM;
`else
  localparam logic [2:0] S_TAIL  = S_DONE;
`endif

  logic [2:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rx_ready_q, rx_ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          xfer;
  logic [31:0]   len_full;

  assign xfer     = rx_valid_i && rx_ready_q;
  assign len_full = {rx_data_i, count_q[23:0]};

  // count_q first assembles the length, then counts down the remaining payload bytes
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN;
          idx_d   = '0;
          count_d = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          count_d[{idx_q, 3'b000} +: 8] = rx_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (len_full > 32'(MEM_BYTES)) begin
              state_d = S_ERROR;
            end else if (len_full == 32'd0) begin
              state_d = S_TAIL;
            end else begin
              state_d = S_LOAD;
              addr_d  = '0;
            end
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d      = 1'b1;
          wr_addr_d = addr_q;
          wdata_d   = rx_data_i;
          addr_d    = addr_q + AW'(1);
          count_d   = count_q - 32'd1;
          if (count_q == 32'd1) state_d = S_TAIL;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR)) begin
      csum_d = 8'h00;
    end else if (state_q == S_LOAD && xfer) begin
      csum_d = csum_q ^ rx_data_i;
    end
  end
`endif

  // status lags the state by one cycle so load_done never overlaps the last write
  always_comb begin
    rx_ready_d = (state_d == S_LEN) || (state_d == S_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    done_d = (state_q == S_DONE) && !start_i;
    err_d  = (state_q == S_ERROR) && !start_i;
    hold_d = !done_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = ADDR_W'(wr_addr_q);
  assign mem_wdata_o  = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign load_done_o  = done_q;
  assign load_error_o = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: monitors transfers and writes, compares against an image-level model.
module tb_imem_loader;
  localparam int MEM_BYTES = 1241;
  localparam int ADDR_W    = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i, start_i, rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              rx_ready_o, mem_we_o, cpu_hold_o, load_done_o, load_error_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;

  always #5 clk_i = ~clk_i;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_hold_o(cpu_hold_o), .load_done_o(load_done_o), .load_error_o(load_error_o)
  );

  typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } rec_t;
  rec_t        acc_q[$];
  rec_t        wr_q[$];
  logic [7:0]  pay_q[$];
  int          cyc = 0;
  int          done_cyc, err_cyc, hold_cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // a transfer seen in cycle k lands on the next edge; its write must show in cycle k+1
  always @(negedge clk_i) begin
    rec_t r;
    #2;
    if (!reset_i && rx_valid_i && rx_ready_o) begin
      r.cyc = cyc; r.addr = 32'd0; r.data = rx_data_i;
      acc_q.push_back(r);
    end
    if (mem_we_o) begin
      r.cyc = cyc; r.addr = mem_addr_o; r.data = mem_wdata_o;
      wr_q.push_back(r);
    end
    if (load_done_o && done_cyc < 0) done_cyc = cyc;
    if (load_error_o && err_cyc < 0) err_cyc = cyc;
    if (!cpu_hold_o && hold_cyc < 0) hold_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xor_of_payload();
    logic [7:0] x = 8'h00;
    foreach (pay_q[i]) x ^= pay_q[i];
    return x;
  endfunction

  task automatic fill_random(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    int t = 0;
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    start_i    = with_start;
    while (!rx_ready_o && t < 20) begin
      @(negedge clk_i);
      start_i = 1'b0;
      t++;
    end
    if (!rx_ready_o) check("send_timeout", 32'(rx_ready_o), 32'd1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      start_i    = 1'b0;
    end
  endtask

  task automatic begin_session();
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    acc_q.delete();
    wr_q.delete();
    done_cyc = -1; err_cyc = -1; hold_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
    check({tag, "_we"},    32'(mem_we_o), 32'd0);
    check({tag, "_addr"},  mem_addr_o, 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    check({tag, "_hold"},  32'(cpu_hold_o), 32'd1);
    check({tag, "_done"},  32'(load_done_o), 32'd0);
    check({tag, "_err"},   32'(load_error_o), 32'd0);
  endtask

  // mode 0: valid held high, 1: valid pattern 1,0,0, 2: random idle gaps
  task automatic session(input string tag, input logic [31:0] len, input int mode,
                         input bit mid_start, input logic [7:0] csum_byte);
    bit len_ok, ok;
    int exp_acc, exp_wr, last;
    begin_session();
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0);
    len_ok = (len <= 32'(MEM_BYTES));
    if (len_ok) begin
      for (int i = 0; i < pay_q.size(); i++) begin
        if (mode == 1) gap(2);
        else if (mode == 2) gap(int'($urandom_range(0, 2)));
        send_byte(pay_q[i], mid_start && (i == pay_q.size() / 2));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csum_byte, 1'b0);
`endif
    end
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hEE;
    start_i    = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);

    ok = len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (len_ok && csum_byte != xor_of_payload()) ok = 1'b0;
`endif
    exp_wr  = len_ok ? int'(len) : 0;
    exp_acc = len_ok ? 4 + exp_wr + CS : 4;
    check({tag, "_acc_cnt"}, 32'(acc_q.size()), 32'(exp_acc));
    check({tag, "_wr_cnt"},  32'(wr_q.size()), 32'(exp_wr));
    for (int i = 0; i < wr_q.size() && i < exp_wr; i++) begin
      check({tag, "_wr_addr"}, wr_q[i].addr, 32'(i));
      check({tag, "_wr_data"}, 32'(wr_q[i].data), 32'(pay_q[i]));
      if (4 + i < acc_q.size()) check({tag, "_wr_lat"}, 32'(wr_q[i].cyc), 32'(acc_q[4+i].cyc + 1));
    end
    last = (acc_q.size() > 0) ? acc_q[acc_q.size()-1].cyc : -100;
    check({tag, "_done"},  32'(load_done_o), 32'(ok));
    check({tag, "_error"}, 32'(load_error_o), 32'(!ok));
    check({tag, "_hold"},  32'(cpu_hold_o), 32'(!ok));
    check({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
    if (ok) begin
      check({tag, "_done_lat"}, 32'(done_cyc), 32'(last + 2));
      check({tag, "_hold_lat"}, 32'(hold_cyc), 32'(last + 2));
    end else begin
      check({tag, "_err_lat"},    32'(err_cyc), 32'(last + 2));
      check({tag, "_hold_never"}, 32'(hold_cyc), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] len8;
    int          b1_cyc, n;
    reset_i = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    done_cyc = -1; err_cyc = -1; hold_cyc = -1;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    reset_i = 1'b0;

    pay_q = '{8'hB7, 8'h12, 8'h00, 8'h00};
    session("t1", 32'd4, 0, 1'b0, xor_of_payload());

    pay_q.delete();
    session("t2a", 32'd0, 0, 1'b0, 8'h00);
    session("t2b", 32'd0, 0, 1'b0, 8'h01);

    session("t3a", 32'h0000_04DA, 0, 1'b0, 8'h00);
    fill_random(MEM_BYTES);
    session("t3b", 32'h0000_04D9, 2, 1'b0, xor_of_payload());
    if (wr_q.size() > 0) check("t3_last_addr", wr_q[wr_q.size()-1].addr, 32'd1240);
    else check("t3_last_addr", 32'hFFFF_FFFF, 32'd1240);

    fill_random(16);
    session("t4", 32'd16, 1, 1'b1, xor_of_payload());

    fill_random(8);
    len8 = 32'd8;
    begin_session();
    for (int i = 0; i < 4; i++) send_byte(len8[8*i +: 8], 1'b0);
    send_byte(pay_q[0], 1'b0);
    send_byte(pay_q[1], 1'b0);
    b1_cyc = cyc;
    @(negedge clk_i);
    reset_i   = 1'b1;
    rx_data_i = pay_q[2];
    @(negedge clk_i);
    check_reset_outputs("t5");
    reset_i    = 1'b0;
    rx_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t5_wr_cnt", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() > 0) check("t5_last_wr_cyc", 32'(wr_q[wr_q.size()-1].cyc), 32'(b1_cyc + 1));
    check("t5_acc_cnt", 32'(acc_q.size()), 32'd6);
    check("t5_hold",  32'(cpu_hold_o), 32'd1);
    check("t5_ready", 32'(rx_ready_o), 32'd0);

    pay_q = '{8'h93, 8'hD2, 8'hC2, 8'h00};
    session("t6a", 32'd4, 0, 1'b0, 8'h83);
    session("t6b", 32'd4, 2, 1'b0, 8'h84);

    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 40));
      fill_random(n);
      session("rnd", 32'(n), 2, r[0],
              ($urandom_range(0, 2) == 0) ? 8'($urandom) : xor_of_payload());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream writer that fills the byte-addressed instruction memory before the core runs. It receives a length-prefixed program image over a valid/ready byte interface and writes one byte per accepted payload byte to the memory write port. Bytes land at consecutive addresses from 0, so the core's little-endian 4-byte fetch sees correct instruction words. It holds the core in reset until the image is complete.

Parameters:
MEM_BYTES, 1241, instruction memory depth in bytes (valid addresses 0..MEM_BYTES-1)
ADDR_W, 32, width of mem_addr; matches PC width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session
rx_valid  input  1  rx_data holds a byte
rx_data  input  8  incoming byte
rx_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  byte write strobe to instruction memory
mem_addr  output  ADDR_W  byte address of write
mem_wdata  output  8  byte to write
cpu_hold  output  1  keeps core in reset / PC at 0
load_done  output  1  image loaded successfully (sticky)
load_error  output  1  session aborted (sticky)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, counters=0.
- Handshake: a byte transfers on any rising edge where rx_valid && rx_ready. rx_ready is registered. It is 1 only in LEN, LOAD and CSUM. The sender may hold rx_valid across stalls.
- IDLE: rx_ready=0. start -> LEN, byte index cleared.
- LEN: accepts 4 bytes that form a 32-bit byte count, little-endian (first byte = bits 7:0).
  - After the 4th byte: count > MEM_BYTES -> ERROR.
  - count == 0 -> DONE (or CSUM when the feature is enabled).
  - Otherwise -> LOAD with addr=0.
- LOAD: each accepted byte produces, on the following cycle, a 1-cycle pulse mem_we=1 with mem_addr=current addr and mem_wdata=byte. Latency from acceptance to write strobe is exactly 1 cycle.
  - addr increments by 1 per accepted byte.
  - On acceptance of byte number count (the last byte): next state DONE (or CSUM). The final mem_we still issues on the cycle after.
  - Back-to-back bytes give back-to-back mem_we pulses, one write per cycle.
- DONE: rx_ready=0, load_done=1, cpu_hold=0. cpu_hold falls in the same cycle load_done rises, which is strictly after the last mem_we pulse.
- ERROR: rx_ready=0, load_error=1, cpu_hold=1. No further writes.
- start in DONE or ERROR: clears load_done and load_error, sets cpu_hold=1, goes to LEN.
- start in LEN, LOAD or CSUM: ignored.
- Arithmetic and width rules:
  - Count register is 32 bits.
  - Address never exceeds MEM_BYTES-1, because count is checked before LOAD.
  - mem_addr is zero-extended to ADDR_W.
- rx_valid while rx_ready=0: no transfer, no state change.
- reset asserted mid-session: returns to the reset state on the next edge. No mem_we follows reset, even if a byte was accepted on the previous cycle. Partial image contents are left in memory.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - The loader keeps an 8-bit XOR of all payload bytes, cleared on start.
  - After the last payload byte the state goes to CSUM, which accepts one byte.
  - Byte equal to the XOR -> DONE. Byte not equal -> ERROR.
  - count==0 expects checksum byte 0x00.
- Not defined: the CSUM state and XOR register do not exist; the last payload byte goes directly to DONE.

Test Plan:
1. reset, start, stream 04 00 00 00 B7 12 00 00 with rx_valid held high -> 4 mem_we pulses, addr 0..3, data B7,12,00,00 on consecutive cycles; load_done=1, cpu_hold=0 one cycle after the last write.
2. Length 00 00 00 00 -> no mem_we; DONE directly (checksum feature on: byte 00 -> DONE, byte 01 -> ERROR).
3. Length 0x000004DA (1242 > 1241) -> load_error=1, cpu_hold=1, rx_ready=0, no writes; then start + length 0x000004D9 plus 1241 bytes -> last write at addr 1240, load_done=1.
4. Payload sent with rx_valid toggling 1,0,0,1,... and start pulsed mid-LOAD -> writes occur only on the cycle after each transfer, addresses contiguous, start has no effect.
5. reset asserted the cycle after byte 2 of an 8-byte payload -> no mem_we after the reset edge, all outputs at reset values, cpu_hold=1.
6. Checksum feature on, payload 93 D2 C2 00 with checksum byte 0x83 -> DONE; same payload with checksum byte 0x84 -> ERROR.
